// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types: machine word and 128-bit cache line.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;
    localparam int PMEM_OFFSET_W = 4;
endpackage

// File: rtl/pmem_line_array.sv
// Line storage: one write port, registered read that clears to zero when idle.
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_idx,
    input  lc3b_c_line       i_wdata,
    output lc3b_c_line       o_rdata
);
    lc3b_c_line r_mem [2**IDX_W];
    lc3b_c_line r_rdata;

    // The read register doubles as the zero-when-not-responding output stage.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
        r_rdata <= i_re ? r_mem[i_idx] : '0;
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/pmem_responder.sv
// Backing store answering the cache's pmem_read/pmem_write line handshake
// after a fixed programmable latency.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int IDX_W   = 5,
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  lc3b_word   pmem_address,
    input  logic       pmem_read,
    input  logic       pmem_write,
    input  lc3b_c_line pmem_wdata,
    output lc3b_c_line pmem_rdata,
    output logic       pmem_resp,
    output logic       pmem_error
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESPOND, S_RECOVER} state_t;

    state_t           r_state, w_next;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_wr;
    lc3b_c_line       r_wdata;
    logic             r_resp, r_error;
    logic             w_req, w_accept, w_done, w_abort, w_we, w_re;
    logic             w_unused_addr;

    assign w_req = pmem_read | pmem_write;
    // Offset bits and aliasing upper bits play no part in line selection.
    assign w_unused_addr = ^pmem_address[PMEM_OFFSET_W-1:0]
                         ^ ^pmem_address[15:PMEM_OFFSET_W+IDX_W];

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            S_IDLE: if (w_req) begin
                w_next   = S_BUSY;
                w_accept = 1'b1;
            end
            S_BUSY: if (!w_req) begin
                w_next  = S_IDLE;
                w_abort = 1'b1;
            end else if (r_cnt == 4'(LATENCY)) begin
                w_next = S_RESPOND;
                w_done = 1'b1;
            end
            S_RESPOND: w_next = S_RECOVER;
            S_RECOVER: if (!w_req) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Commit or fetch on the edge entering RESPOND; a reset edge cancels both.
    assign w_we = w_done &  r_wr & ~reset;
    assign w_re = w_done & ~r_wr & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_resp  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_resp  <= w_done;
            r_error <= (w_accept & pmem_read & pmem_write) | w_abort;
            if (w_accept) r_cnt <= 4'd1;
            else if (r_state == S_BUSY) r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= pmem_address[PMEM_OFFSET_W +: IDX_W];
            r_wr    <= pmem_write;
            r_wdata <= pmem_wdata;
        end
    end

    pmem_line_array #(.IDX_W(IDX_W)) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (pmem_rdata)
    );

    assign pmem_resp  = r_resp;
    assign pmem_error = r_error;
endmodule

// File: tb/tb_pmem_responder.sv
// Vector table plus scoreboard for pmem_responder; corner cases hand-sequenced.
module tb_pmem_responder;
    import lc3b_types::*;

    localparam int IDX_W = 5;
    localparam int LAT   = 4;

    logic       clk = 1'b0;
    logic       reset, rd, wr;
    lc3b_word   addr;
    lc3b_c_line wdata, rdata;
    logic       resp, err;

    always #5 clk = ~clk;

    pmem_responder #(.IDX_W(IDX_W), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .pmem_address (addr),
        .pmem_read    (rd),
        .pmem_write   (wr),
        .pmem_wdata   (wdata),
        .pmem_rdata   (rdata),
        .pmem_resp    (resp),
        .pmem_error   (err)
    );

    typedef struct {logic rd; lc3b_c_line data;} sb_t;
    typedef struct {logic r; logic w; lc3b_word a; lc3b_c_line d; lc3b_c_line ex; int e;} vec_t;

    localparam lc3b_c_line LA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam lc3b_c_line DA = 128'hAAAA5555_11112222_33334444_AAAA0001;
    localparam lc3b_c_line DB = 128'hBBBB0000_BBBB1111_BBBB2222_BBBB3333;
    localparam lc3b_c_line DD = 128'hD0D0D0D0_0D0D0D0D_12345678_9ABCDEF0;
    localparam lc3b_c_line DP = 128'h50505050_A0A0A0A0_0F0F0F0F_F0F0F0F0;
    localparam lc3b_c_line DC = 128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCC;

    sb_t  sb[$];
    sb_t  sb_e;
    vec_t v[11];
    int   n_cmp = 0, n_bad = 0, err_cnt = 0;

    task automatic chk(input string name, input lc3b_c_line act, input lc3b_c_line exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every resp must match a pending request.
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (resp === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got resp=1 want 0");
            end else begin
                sb_e = sb.pop_front();
                if (sb_e.rd) chk("sb_rdata", rdata, sb_e.data);
            end
        end else if (reset === 1'b0) begin
            chk("rdata_idle", rdata, '0);
        end
    end

    // Issue one request from a negedge, wait for resp, optionally hold, then drop.
    task automatic do_op(input logic r, input logic w, input lc3b_word a, input lc3b_c_line d,
                         input lc3b_c_line ex, input int hold, output int lat);
        lat = -1;
        sb.push_back('{rd: r & ~w, data: ex});
        rd = r; wr = w; addr = a; wdata = d;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(negedge clk);
            if (resp === 1'b1) lat = i;
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no resp want resp");
            if (sb.size() > 0) void'(sb.pop_back());
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("held_no_resp", 128'(resp), 128'(0));
            end
        end
        rd = 1'b0; wr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("resp_one_cycle", 128'(resp), 128'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int lat, e0;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_resp",  128'(resp), 128'(0));
        chk("reset_rdata", rdata, '0);
        chk("reset_err",   128'(err), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        v[0]  = '{1'b0, 1'b1, 16'h1230, LA, '0, 0};
        v[1]  = '{1'b1, 1'b0, 16'h1230, '0, LA, 0};
        v[2]  = '{1'b0, 1'b1, 16'h4560, DA, '0, 0};
        v[3]  = '{1'b1, 1'b0, 16'h4560, '0, DA, 0};
        v[4]  = '{1'b0, 1'b1, 16'h0020, DB, '0, 0};
        v[5]  = '{1'b1, 1'b0, 16'h0220, '0, DB, 0};
        v[6]  = '{1'b1, 1'b0, 16'h002F, '0, DB, 0};
        v[7]  = '{1'b1, 1'b1, 16'h0010, DD, '0, 1};
        v[8]  = '{1'b1, 1'b0, 16'h0010, '0, DD, 0};
        v[9]  = '{1'b0, 1'b1, 16'h0100, DP, '0, 0};
        v[10] = '{1'b1, 1'b0, 16'h0300, '0, DP, 0};

        for (int i = 0; i < 11; i++) begin
            e0 = err_cnt;
            do_op(v[i].r, v[i].w, v[i].a, v[i].d, v[i].ex, 0, lat);
            chk($sformatf("v%0d_latency", i), 128'(lat), 128'(LAT + 1));
            chk($sformatf("v%0d_err", i), 128'(err_cnt - e0), 128'(v[i].e));
        end

        // Held request: no second resp while read stays high, then a fresh one.
        e0 = err_cnt;
        do_op(1'b1, 1'b0, 16'h1230, '0, LA, 3, lat);
        chk("held_latency", 128'(lat), 128'(LAT + 1));
        do_op(1'b1, 1'b0, 16'h1230, '0, LA, 0, lat);
        chk("reissue_latency", 128'(lat), 128'(LAT + 1));
        chk("held_err", 128'(err_cnt - e0), 128'(0));

        // Abort a write in BUSY cycle 2: no commit, one error pulse, IDLE next.
        e0 = err_cnt;
        wr = 1'b1; addr = 16'h1230; wdata = DC;
        repeat (2) @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        chk("abort_err_pulse", 128'(err), 128'(1));
        do_op(1'b1, 1'b0, 16'h1230, '0, LA, 0, lat);
        chk("abort_idle_latency", 128'(lat), 128'(LAT + 1));
        chk("abort_err_count", 128'(err_cnt - e0), 128'(1));

        // Reset during BUSY of a write: discarded, outputs quiet.
        wr = 1'b1; addr = 16'h0100; wdata = DC;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_resp",  128'(resp), 128'(0));
        chk("rst_mid_rdata", rdata, '0);
        chk("rst_mid_err",   128'(err), 128'(0));
        @(negedge clk);
        reset = 1'b0; wr = 1'b0;
        @(negedge clk);
        do_op(1'b1, 1'b0, 16'h0100, '0, DP, 0, lat);
        chk("rst_read_latency", 128'(lat), 128'(LAT + 1));

        repeat (3) @(negedge clk);
        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Physical-memory side of the cache's pmem_read / pmem_write / pmem_resp line interface.
- Accepts one 128-bit line request at a time and holds it for a programmable latency.
- Then answers with a single-cycle pmem_resp, carrying read data or committing write data.
- Serves as the synthesizable backing store beneath the L1 cache controller.
- Obeys the requester's rule that the request drops for at least one cycle after each pmem_resp.

Parameters:
- IDX_W, 5: log2 of line count; array holds 2^IDX_W lines of 128 bits.
- LATENCY, 4: cycles from request acceptance to pmem_resp; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- pmem_address  in  16  byte address (lc3b_word); bits [3:0] ignored; line index = bits [4+IDX_W-1:4], upper bits alias (wrap).
- pmem_read  in  1  line read request, held high until pmem_resp.
- pmem_write  in  1  line write request, held high until pmem_resp.
- pmem_wdata  in  128  write line data.
- pmem_rdata  out  128  read line data; valid only while pmem_resp=1.
- pmem_resp  out  1  one-cycle completion strobe.
- pmem_error  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset: state=IDLE, counter=0, pmem_resp=0, pmem_rdata=0, pmem_error=0. The line array is NOT cleared, so contents are undefined until written.
- All outputs are registered.
- FSM states:
  - IDLE: if pmem_read|pmem_write is sampled high at an edge, latch the index, the op (write if pmem_write) and pmem_wdata; counter=1; go to BUSY.
  - BUSY: counter increments each cycle. When counter==LATENCY, go to RESPOND.
    - If the latched op is write, commit the line on that same edge.
    - If the latched op is read, load pmem_rdata from the array on that same edge.
  - RESPOND: pmem_resp=1 for exactly one cycle; next state is RECOVER. pmem_rdata returns to 0 on leaving RESPOND.
  - RECOVER: ignore requests. Stay while pmem_read|pmem_write is high, and go to IDLE on the first edge where both are low. Minimum 1 cycle.
- Latency: request sampled at edge k in IDLE gives pmem_resp high during the cycle following edge k+LATENCY. For LATENCY=1 this is the cycle after edge k+1.
- Address and wdata are latched at acceptance; later changes during BUSY are ignored.
- Both read and write high at acceptance: treat as write, pulse pmem_error in the next cycle.
- Request dropped during BUSY (abort): return to IDLE next edge with no commit, no pmem_resp, and a pmem_error pulse.
- A write followed by a read of the same line returns the new data. The commit happens before RESPOND, so there is no hazard window.
- Reset asserted mid-BUSY: return to IDLE immediately. An uncommitted write is discarded; a write already committed stays.
- Index wrap: 0x0000 and 0x0000 + (16 << IDX_W) map to the same line.

Decomposition:
- lc3b_types package:
  - lc3b_word (16-bit) and lc3b_c_line (128-bit) types.
  - Constant PMEM_OFFSET_W=4.
- The FSM state enum stays local to the module.
- One sub-module, pmem_line_array: 2^IDX_W x 128 register array with single write port (we, index, data), a registered read, and no reset.

Test Plan:
- Read latency (LATENCY=4): write line 0x1230 := 0xDEADBEEF_...; then pmem_read=1 at 0x1230 from edge k → pmem_resp exactly in the cycle after edge k+4, pmem_rdata = the written line, resp high for 1 cycle only.
- Cache writeback sequence: pmem_write 0x4560 data A, responder resps, requester drops for 1 cycle, then pmem_read 0x4560 → rdata=A; no pmem_error.
- Held request: keep pmem_read high 3 cycles after pmem_resp → responder stays in RECOVER with no second resp. Drop the request, reissue → a new resp LATENCY cycles later.
- Protocol errors:
  - read and write both high at 0x0010 → write commits, pmem_error pulses once.
  - drop pmem_read at BUSY cycle 2 → no pmem_resp, pmem_error pulses, IDLE next cycle.
- Aliasing (IDX_W=5): write 0x0020 := B, read 0x0220 → rdata=B. Read 0x002F → rdata=B (offset ignored).
- Reset mid-operation: assert reset during BUSY of a write to 0x0100 with data C → pmem_resp never asserts, outputs 0. A later read of 0x0100 returns the prior contents, not C.
